// File: rtl/sha256_block_sequencer.sv
// ---------------------------------------------------------------------------
// sha256_block_sequencer
//
// Front end of the SHA-256 compression engine. Accepts one 512-bit message
// block at a time, expands it into the 64 message-schedule words W_t with a
// 16-word sliding window, looks up the round constant K_t, and generates the
// control strobes consumed by the round datapath.
//
// Optional feature macro: SCHED_STALL_EN
//   When defined, an extra input round_hold freezes the round sequence
//   (counter, window and the W/K/index outputs) while it is high in ROUND.
//   When undefined, the port does not exist and the 64 rounds always run
//   back to back.
//
// Ports:
//   clk            in   clock
//   reset_n        in   asynchronous, active-low reset
//   blk_valid      in   block offered
//   blk_ready      out  sequencer can accept a block (high only in IDLE)
//   blk_data[511:0]in   message block, word 0 in bits [511:480]
//   blk_first      in   block starts a new message (qualified by blk_valid)
//   blk_last       in   block ends the message (qualified by blk_valid)
//   round_hold     in   (SCHED_STALL_EN only) stall the current round
//   init           out  one-cycle pulse: datapath loads the IV
//   round_en       out  datapath performs round round_idx this cycle
//   digest_update  out  one-cycle pulse: datapath adds working vars to H
//   done           out  final digest valid; held until next block accepted
//   w_out[31:0]    out  W_t for the current round (0 outside ROUND)
//   k_out[31:0]    out  K_t for the current round (0 outside ROUND)
//   round_idx[5:0] out  current round t (0 outside ROUND)
//   busy           out  high in every state except IDLE
//
// Handshake: a block transfers on a rising clk edge where blk_valid and
// blk_ready are both high. blk_ready is a pure function of the state, never
// of blk_valid; the offering side may hold blk_valid high for any number of
// cycles and the block is taken on the first IDLE cycle.
// ---------------------------------------------------------------------------
module sha256_block_sequencer (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         blk_valid,
    output logic         blk_ready,
    input  logic [511:0] blk_data,
    input  logic         blk_first,
    input  logic         blk_last,
`ifdef SCHED_STALL_EN
    input  logic         round_hold,
`endif
    output logic         init,
    output logic         round_en,
    output logic         digest_update,
    output logic         done,
    output logic [31:0]  w_out,
    output logic [31:0]  k_out,
    output logic [5:0]   round_idx,
    output logic         busy
);

    // Fixed by the SHA-256 algorithm.
    localparam int ROUNDS = 64;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_INIT   = 2'd1;
    localparam logic [1:0] ST_ROUND  = 2'd2;
    localparam logic [1:0] ST_UPDATE = 2'd3;

    localparam logic [31:0] K_TABLE [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Small sigma functions of the message schedule.
    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    logic [1:0]  state;
    logic [5:0]  t;
    logic        last_q;
    logic [31:0] w [0:15];
    logic [31:0] w_new;
    logic        hold;
    logic        in_round;

`ifdef SCHED_STALL_EN
    assign hold = round_hold;
`else
    assign hold = 1'b0;
`endif

    assign in_round = (state == ST_ROUND);

    // Window holds W_t .. W_t+15; this is W_t+16.
    assign w_new = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= ST_IDLE;
            t      <= 6'd0;
            last_q <= 1'b0;
            done   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                w[i] <= 32'd0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (blk_valid) begin
                        for (int i = 0; i < 16; i++) begin
                            w[i] <= blk_data[511 - 32*i -: 32];
                        end
                        last_q <= blk_last;
                        done   <= 1'b0;
                        t      <= 6'd0;
                        // A first block always restarts the message,
                        // even if the previous one never finished.
                        state  <= blk_first ? ST_INIT : ST_ROUND;
                    end
                end
                ST_INIT: begin
                    state <= ST_ROUND;
                end
                ST_ROUND: begin
                    if (!hold) begin
                        for (int i = 0; i < 15; i++) begin
                            w[i] <= w[i+1];
                        end
                        w[15] <= w_new;
                        t     <= t + 6'd1;
                        if (t == 6'(ROUNDS - 1)) begin
                            state <= ST_UPDATE;
                        end
                    end
                end
                ST_UPDATE: begin
                    if (last_q) begin
                        done <= 1'b1;
                    end
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // All strobes decode directly from the state register so they drop
    // to zero immediately on an asynchronous reset.
    assign blk_ready     = (state == ST_IDLE);
    assign busy          = (state != ST_IDLE);
    assign init          = (state == ST_INIT);
    assign digest_update = (state == ST_UPDATE);
    assign round_en      = in_round && !hold;
    assign w_out         = in_round ? w[0] : 32'd0;
    assign k_out         = in_round ? K_TABLE[t] : 32'd0;
    assign round_idx     = in_round ? t : 6'd0;

endmodule

// File: tb/tb_sha256_block_sequencer.sv
// ---------------------------------------------------------------------------
// tb_sha256_block_sequencer
//
// Directed bench for sha256_block_sequencer. A behavioural SHA-256 round
// datapath is attached to the strobes so complete messages can be compared
// against published digests. Cycle numbering: the accept edge is cycle 0,
// cycle n is the clock period that ends at the n-th edge after it.
// ---------------------------------------------------------------------------
module tb_sha256_block_sequencer;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] blk_data;
    logic         blk_first;
    logic         blk_last;
`ifdef SCHED_STALL_EN
    logic         round_hold;
`endif
    logic         init;
    logic         round_en;
    logic         digest_update;
    logic         done;
    logic [31:0]  w_out;
    logic [31:0]  k_out;
    logic [5:0]   round_idx;
    logic         busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sha256_block_sequencer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .blk_valid     (blk_valid),
        .blk_ready     (blk_ready),
        .blk_data      (blk_data),
        .blk_first     (blk_first),
        .blk_last      (blk_last),
`ifdef SCHED_STALL_EN
        .round_hold    (round_hold),
`endif
        .init          (init),
        .round_en      (round_en),
        .digest_update (digest_update),
        .done          (done),
        .w_out         (w_out),
        .k_out         (k_out),
        .round_idx     (round_idx),
        .busy          (busy)
    );

    // ---------------- stimulus data ----------------
    localparam logic [511:0] MSG_ABC = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [255:0] DIG_ABC =
        256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
    localparam logic [511:0] MSG_2A = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] MSG_2B = {480'h0, 32'h000001c0};
    localparam logic [255:0] DIG_2 =
        256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    // ---------------- reference round datapath ----------------
    logic [31:0]  hs [0:7];
    logic [31:0]  v  [0:7];
    logic [31:0]  t1, t2;
    logic [255:0] digest;
    int           upd_seen = 0;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    assign digest = {hs[0], hs[1], hs[2], hs[3], hs[4], hs[5], hs[6], hs[7]};

    always @(negedge clk) begin
        if (init) begin
            for (int i = 0; i < 8; i++) begin
                hs[i] = IV[i];
                v[i]  = IV[i];
            end
        end else if (round_en) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
               + ((v[4] & v[5]) ^ (~v[4] & v[6])) + k_out + w_out;
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
               + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end else if (digest_update) begin
            upd_seen++;
            for (int i = 0; i < 8; i++) begin
                hs[i] = hs[i] + v[i];
                v[i]  = hs[i];
            end
        end
    end

    // ---------------- per-cycle capture ----------------
    localparam int NCYC = 80;
    logic        cap_init  [1:NCYC];
    logic        cap_ren   [1:NCYC];
    logic        cap_upd   [1:NCYC];
    logic        cap_done  [1:NCYC];
    logic        cap_ready [1:NCYC];
    logic        cap_busy  [1:NCYC];
    logic [31:0] cap_w     [1:NCYC];
    logic [31:0] cap_k     [1:NCYC];
    logic [5:0]  cap_idx   [1:NCYC];
    int          hold_from = 0;
    int          hold_len  = 0;

    // Offer a block while the DUT is idle, then record cycles 1..ncyc.
    // With keep_valid the offer stays up after the accept edge.
    task automatic send_block(input logic [511:0] data, input logic first,
                              input logic last, input int ncyc,
                              input logic keep_valid);
        blk_data  = data;
        blk_first = first;
        blk_last  = last;
        blk_valid = 1'b1;
        @(posedge clk); #1;
        if (!keep_valid) blk_valid = 1'b0;
        for (int c = 1; c <= ncyc; c++) begin
`ifdef SCHED_STALL_EN
            round_hold = (hold_len > 0) && (c >= hold_from) && (c < hold_from + hold_len);
`endif
            #1;
            cap_init[c]  = init;
            cap_ren[c]   = round_en;
            cap_upd[c]   = digest_update;
            cap_done[c]  = done;
            cap_ready[c] = blk_ready;
            cap_busy[c]  = busy;
            cap_w[c]     = w_out;
            cap_k[c]     = k_out;
            cap_idx[c]   = round_idx;
            if (c < ncyc) begin
                @(posedge clk); #1;
            end
        end
`ifdef SCHED_STALL_EN
        round_hold = 1'b0;
`endif
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int u;
        reset_n = 1'b0;
        #1;
        checks++; if ({blk_ready, init, round_en, digest_update, done, busy} !== 6'b100000) begin
            failures++; $display("FAIL reset_strobes got=%b exp=100000",
                {blk_ready, init, round_en, digest_update, done, busy});
        end
        checks++; if ({w_out, k_out, round_idx} !== 70'd0) begin
            failures++; $display("FAIL reset_data got=%h exp=0", {w_out, k_out, round_idx});
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        // Abort mid-round at t=30 (cycle 32 for a first block).
        send_block(MSG_ABC, 1'b1, 1'b1, 32, 1'b0);
        checks++; if (cap_idx[32] !== 6'd30) begin
            failures++; $display("FAIL reset_pre_idx got=%0d exp=30", cap_idx[32]);
        end
        u = upd_seen;
        reset_n = 1'b0;
        #1;
        checks++; if ({blk_ready, init, round_en, digest_update, done, busy} !== 6'b100000) begin
            failures++; $display("FAIL reset_mid_strobes got=%b exp=100000",
                {blk_ready, init, round_en, digest_update, done, busy});
        end
        checks++; if ({w_out, k_out, round_idx} !== 70'd0) begin
            failures++; $display("FAIL reset_mid_data got=%h exp=0", {w_out, k_out, round_idx});
        end
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        checks++; if (upd_seen !== u) begin
            failures++; $display("FAIL reset_no_update got=%0d exp=%0d", upd_seen, u);
        end
        checks++; if (busy !== 1'b0) begin
            failures++; $display("FAIL reset_idle_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_abc();
        logic in_r;
        send_block(MSG_ABC, 1'b1, 1'b1, 67, 1'b0);
        for (int c = 1; c <= 67; c++) begin
            in_r = (c >= 2) && (c <= 65);
            checks++; if (cap_init[c] !== (c == 1)) begin
                failures++; $display("FAIL abc_init c=%0d got=%b", c, cap_init[c]);
            end
            checks++; if (cap_ren[c] !== in_r) begin
                failures++; $display("FAIL abc_round_en c=%0d got=%b exp=%b", c, cap_ren[c], in_r);
            end
            checks++; if (cap_idx[c] !== (in_r ? 6'(c - 2) : 6'd0)) begin
                failures++; $display("FAIL abc_idx c=%0d got=%0d", c, cap_idx[c]);
            end
            checks++; if (cap_upd[c] !== (c == 66)) begin
                failures++; $display("FAIL abc_update c=%0d got=%b", c, cap_upd[c]);
            end
            checks++; if ({cap_ready[c], cap_busy[c], cap_done[c]} !== ((c == 67) ? 3'b101 : 3'b010)) begin
                failures++; $display("FAIL abc_rdy_busy_done c=%0d got=%b",
                    c, {cap_ready[c], cap_busy[c], cap_done[c]});
            end
            if (!in_r) begin
                checks++; if ({cap_w[c], cap_k[c]} !== 64'd0) begin
                    failures++; $display("FAIL abc_wk_idle c=%0d got=%h exp=0", c, {cap_w[c], cap_k[c]});
                end
            end
        end
        checks++; if (cap_w[2] !== 32'h61626380) begin
            failures++; $display("FAIL abc_w0 got=%h exp=61626380", cap_w[2]);
        end
        checks++; if (cap_w[17] !== 32'h00000018) begin
            failures++; $display("FAIL abc_w15 got=%h exp=00000018", cap_w[17]);
        end
        checks++; if (cap_w[18] !== 32'h61626380) begin
            failures++; $display("FAIL abc_w16 got=%h exp=61626380", cap_w[18]);
        end
        checks++; if (cap_w[19] !== 32'h000f0000) begin
            failures++; $display("FAIL abc_w17 got=%h exp=000f0000", cap_w[19]);
        end
        checks++; if (cap_k[2] !== 32'h428a2f98) begin
            failures++; $display("FAIL abc_k0 got=%h exp=428a2f98", cap_k[2]);
        end
        checks++; if (cap_k[65] !== 32'hc67178f2) begin
            failures++; $display("FAIL abc_k63 got=%h exp=c67178f2", cap_k[65]);
        end
        checks++; if (digest !== DIG_ABC) begin
            failures++; $display("FAIL abc_digest got=%h exp=%h", digest, DIG_ABC);
        end
    endtask

    task automatic test_two_block();
        send_block(MSG_2A, 1'b1, 1'b0, 67, 1'b0);
        checks++; if ({cap_init[1], cap_upd[66], cap_done[67], cap_ready[67]} !== 4'b1101) begin
            failures++; $display("FAIL two_blk1_seq got=%b exp=1101",
                {cap_init[1], cap_upd[66], cap_done[67], cap_ready[67]});
        end
        for (int c = 2; c <= 65; c++) begin
            checks++; if (cap_ready[c] !== 1'b0) begin
                failures++; $display("FAIL two_blk1_ready c=%0d got=%b exp=0", c, cap_ready[c]);
            end
        end
        // Offered on the first IDLE cycle after the first block's update.
        send_block(MSG_2B, 1'b0, 1'b1, 66, 1'b0);
        for (int c = 1; c <= 66; c++) begin
            checks++; if (cap_init[c] !== 1'b0) begin
                failures++; $display("FAIL two_blk2_init c=%0d got=%b exp=0", c, cap_init[c]);
            end
            checks++; if (cap_ready[c] !== (c == 66)) begin
                failures++; $display("FAIL two_blk2_ready c=%0d got=%b", c, cap_ready[c]);
            end
            checks++; if (cap_ren[c] !== (c <= 64)) begin
                failures++; $display("FAIL two_blk2_round_en c=%0d got=%b", c, cap_ren[c]);
            end
        end
        checks++; if ({cap_idx[1], cap_idx[64]} !== {6'd0, 6'd63}) begin
            failures++; $display("FAIL two_blk2_idx got=%0d,%0d exp=0,63", cap_idx[1], cap_idx[64]);
        end
        checks++; if ({cap_upd[65], cap_done[65], cap_done[66]} !== 3'b101) begin
            failures++; $display("FAIL two_blk2_done got=%b exp=101",
                {cap_upd[65], cap_done[65], cap_done[66]});
        end
        checks++; if (digest !== DIG_2) begin
            failures++; $display("FAIL two_digest got=%h exp=%h", digest, DIG_2);
        end
    endtask

    task automatic test_handshake();
        // done=1 from the previous message; valid stays high the whole time.
        send_block(MSG_ABC, 1'b0, 1'b1, 66, 1'b1);
        for (int c = 1; c <= 64; c++) begin
            checks++; if ({cap_ready[c], cap_idx[c]} !== {1'b0, 6'(c - 1)}) begin
                failures++; $display("FAIL hs_round c=%0d got ready=%b idx=%0d",
                    c, cap_ready[c], cap_idx[c]);
            end
        end
        checks++; if ({cap_ready[66], cap_done[66], cap_busy[66]} !== 3'b110) begin
            failures++; $display("FAIL hs_idle got=%b exp=110",
                {cap_ready[66], cap_done[66], cap_busy[66]});
        end
        // Swap the offer to a fresh single-block message before the edge.
        blk_data  = MSG_ABC;
        blk_first = 1'b1;
        blk_last  = 1'b1;
        @(posedge clk); #1;
        blk_valid = 1'b0;
        checks++; if ({done, init, blk_ready} !== 3'b010) begin
            failures++; $display("FAIL hs_accept got=%b exp=010", {done, init, blk_ready});
        end
        for (int i = 0; i < 100 && busy; i++) begin
            @(posedge clk); #1;
        end
        checks++; if ({busy, done} !== 2'b01) begin
            failures++; $display("FAIL hs_finish got busy,done=%b exp=01", {busy, done});
        end
        checks++; if (digest !== DIG_ABC) begin
            failures++; $display("FAIL hs_digest got=%h exp=%h", digest, DIG_ABC);
        end
    endtask

`ifdef SCHED_STALL_EN
    task automatic test_stall();
        hold_from = 12;
        hold_len  = 5;
        send_block(MSG_ABC, 1'b1, 1'b1, 72, 1'b0);
        hold_len  = 0;
        for (int c = 12; c <= 17; c++) begin
            checks++; if ({cap_idx[c], cap_w[c], cap_k[c]} !== {6'd10, 32'h0, 32'h243185be}) begin
                failures++; $display("FAIL stall_hold c=%0d got idx=%0d w=%h k=%h",
                    c, cap_idx[c], cap_w[c], cap_k[c]);
            end
            checks++; if (cap_ren[c] !== (c == 17)) begin
                failures++; $display("FAIL stall_round_en c=%0d got=%b", c, cap_ren[c]);
            end
        end
        checks++; if ({cap_upd[66], cap_upd[71], cap_done[71], cap_done[72]} !== 4'b0101) begin
            failures++; $display("FAIL stall_timing got=%b exp=0101",
                {cap_upd[66], cap_upd[71], cap_done[71], cap_done[72]});
        end
        checks++; if (digest !== DIG_ABC) begin
            failures++; $display("FAIL stall_digest got=%h exp=%h", digest, DIG_ABC);
        end
    endtask
`endif

    initial begin
        blk_valid = 1'b0;
        blk_data  = '0;
        blk_first = 1'b0;
        blk_last  = 1'b0;
`ifdef SCHED_STALL_EN
        round_hold = 1'b0;
`endif
        test_reset();
        test_abc();
        test_two_block();
        test_handshake();
`ifdef SCHED_STALL_EN
        test_stall();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
